// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Collects results from NUM_FU functional units and broadcasts them one per
// unstalled cycle on the common data bus (CDB) that feeds the ROB. Each FU has
// its own small FIFO of {tag, value} entries. A round-robin pointer picks the
// next non-empty FIFO. The selected head is registered onto the CDB outputs.
//
// Parameters
//   NUM_FU    number of functional-unit result ports
//   TAG_WIDTH ROB tag width (matches the ROB address width)
//   DEPTH     per-FU FIFO depth (power of two, >= 2)
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous, active-low reset
//   stall_i      pipeline stall (shared with the ROB); freezes pops and the CDB
//   flush_i      synchronous discard of every buffered result and the CDB
//   fu_valid_i   per-FU result valid
//   fu_tag_i     per-FU ROB tag, FU i at [i*TAG_WIDTH +: TAG_WIDTH]
//   fu_value_i   per-FU result, FU i at [i*`XLEN +: `XLEN]
//   fu_ready_o   per-FU accept, high while that FU's FIFO is not full
//   cdb_valid_o  broadcast valid
//   cdb_tag_o    broadcast ROB tag
//   cdb_value_o  broadcast result
//   cdb_src_o    one-hot source FU of the broadcast, zero when not valid
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module cdb_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int TAG_WIDTH = 3,
  parameter int DEPTH     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall_i,
  input  logic                          flush_i,
  input  logic [NUM_FU-1:0]             fu_valid_i,
  input  logic [NUM_FU*TAG_WIDTH-1:0]   fu_tag_i,
  input  logic [NUM_FU*`XLEN-1:0]       fu_value_i,
  output logic [NUM_FU-1:0]             fu_ready_o,
  output logic                          cdb_valid_o,
  output logic [TAG_WIDTH-1:0]          cdb_tag_o,
  output logic [`XLEN-1:0]              cdb_value_o,
  output logic [NUM_FU-1:0]             cdb_src_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int RR_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int ENTRY_W = TAG_WIDTH + `XLEN;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [RR_W-1:0]  LAST_FU   = RR_W'(NUM_FU - 1);

  // FIFO storage and bookkeeping
  logic [ENTRY_W-1:0] mem_q    [NUM_FU][DEPTH];
  logic [ENTRY_W-1:0] mem_d    [NUM_FU][DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q [NUM_FU];
  logic [PTR_W-1:0]   wr_ptr_d [NUM_FU];
  logic [PTR_W-1:0]   rd_ptr_q [NUM_FU];
  logic [PTR_W-1:0]   rd_ptr_d [NUM_FU];
  logic [CNT_W-1:0]   count_q  [NUM_FU];
  logic [CNT_W-1:0]   count_d  [NUM_FU];

  // Arbitration state and CDB output registers
  logic [RR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 cdb_valid_q, cdb_valid_d;
  logic [TAG_WIDTH-1:0] cdb_tag_q, cdb_tag_d;
  logic [`XLEN-1:0]     cdb_value_q, cdb_value_d;
  logic [NUM_FU-1:0]    cdb_src_q, cdb_src_d;

  // Combinational helpers
  logic [RR_W-1:0]    cand       [NUM_FU];
  logic               grant_valid;
  logic [RR_W-1:0]    grant_idx;
  logic [ENTRY_W-1:0] grant_entry;
  logic [NUM_FU-1:0]  push_en;
  logic [NUM_FU-1:0]  pop_en;

  // A full FIFO never accepts, even on the edge where it pops.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready_o[i] = (count_q[i] != DEPTH_CNT);
    end
  end

  // Round-robin search starting at rr_ptr. The loop runs downward so the last
  // hit written is the closest one to rr_ptr, which avoids a loop break.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      cand[k] = RR_W'((int'(rr_ptr_q) + k) % NUM_FU);
    end
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      if (count_q[cand[k]] != '0) begin
        grant_valid = 1'b1;
        grant_idx   = cand[k];
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

  // Head entry of the granted FIFO.
  always_comb begin
    grant_entry = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant_idx == RR_W'(i)) begin
        grant_entry = mem_q[i][rd_ptr_q[i]];
      end else begin
        grant_entry = grant_entry;
      end
    end
  end

  // Push and pop enables; flush suppresses both, stall only blocks pops.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      push_en[i] = fu_valid_i[i] && fu_ready_o[i] && !flush_i;
      pop_en[i]  = grant_valid && (grant_idx == RR_W'(i)) && !stall_i && !flush_i;
    end
  end

  // Next-state for the FIFO storage, pointers and counts.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NUM_FU; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (flush_i) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        count_d[i]  = '0;
      end else begin
        if (push_en[i]) begin
          mem_d[i][wr_ptr_q[i]] = {fu_tag_i[i*TAG_WIDTH +: TAG_WIDTH],
                                   fu_value_i[i*`XLEN +: `XLEN]};
          wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
        end else begin
          wr_ptr_d[i] = wr_ptr_q[i];
        end
        if (pop_en[i]) begin
          rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
        end else begin
          rd_ptr_d[i] = rd_ptr_q[i];
        end
        case ({push_en[i], pop_en[i]})
          2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
          2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
          default: count_d[i] = count_q[i];
        endcase
      end
    end
  end

  // Next-state for the CDB registers and the round-robin pointer.
  always_comb begin
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    cdb_src_d   = cdb_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (flush_i) begin
      cdb_valid_d = 1'b0;
      cdb_src_d   = '0;
    end else if (stall_i) begin
      // Hold the current broadcast so the ROB sees it once unstalled.
      cdb_valid_d = cdb_valid_q;
    end else if (grant_valid) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = grant_entry[ENTRY_W-1 -: TAG_WIDTH];
      cdb_value_d = grant_entry[`XLEN-1:0];
      cdb_src_d   = NUM_FU'(1) << grant_idx;
      rr_ptr_d    = (grant_idx == LAST_FU) ? '0 : grant_idx + RR_W'(1);
    end else begin
      // Nothing to send: drop valid, keep tag and value stable.
      cdb_valid_d = 1'b0;
      cdb_src_d   = '0;
    end
  end

  // FIFO data array; contents are qualified by count, so no reset needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
      cdb_src_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid_o = cdb_valid_q;
  assign cdb_tag_o   = cdb_tag_q;
  assign cdb_value_o = cdb_value_q;
  assign cdb_src_o   = cdb_src_q;

endmodule
